cache_bank_ram: RTL and testbench
=================================

Name: cache_bank_ram

Overview:
- One 32-bit data bank of a cache way: 2^ADDR_WIDTH words, byte-granular writes, combinational read.
- A way holds DATA_WORD_NUM of these banks side by side, one per word of the line.
- The way controller drives wr_en per bank (way write & word enable), shares wr_byte_en, and uses the same index for read and write.

Parameters:
- ADDR_WIDTH, 5, index width; depth = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- BYTE_NUM, DATA_WIDTH/8 (4), number of byte lanes / width of wr_byte_en.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe for this bank, sampled on posedge clk.
- wr_addr  input  ADDR_WIDTH  write index.
- wr_data  input  DATA_WIDTH  write data; byte k = bits [8k+7:8k].
- wr_byte_en  input  BYTE_NUM  per-byte write enable; bit k gates byte k.
- rd_addr  input  ADDR_WIDTH  read index.
- rd_data  output  DATA_WIDTH  combinational read of entry rd_addr.

Behaviour:
- Storage: 2^ADDR_WIDTH x DATA_WIDTH array, organised as BYTE_NUM independent byte lanes.
- Reset: while rst=1, every entry is 0, so rd_data = 0 for any rd_addr. Assertion takes effect immediately, without waiting for a clock edge.
- Writes are ignored while rst=1. A write edge coinciding with reset assertion is lost.
- Write: on posedge clk with rst=0 and wr_en=1, for each k with wr_byte_en[k]=1, byte k of entry wr_addr takes wr_data byte k. Other bytes and entries hold.
- wr_en=1 with wr_byte_en=0 is a legal no-op.
- Read: rd_data = mem[rd_addr] combinationally, with zero-cycle latency and no read enable.
- Read-during-write, same address: before the edge, rd_data shows the old contents. After the edge it shows the merged new word, with no bypass path.
- Different addresses are fully independent.
- Address range is exactly 0 .. 2^ADDR_WIDTH-1; no wrap logic is needed and there are no illegal addresses.
- No X on rd_data after the first reset.

Optional Feature:
- Macro: CACHE_BANK_RAM_PARITY_EN.
- Defined:
  - Each byte lane stores an extra even-parity bit, written together with its byte.
  - Reset value of every parity bit is 0, which is consistent with a zero byte.
  - Adds output rd_parity_err (1 bit, combinational): OR over lanes of (XOR of stored byte and its stored parity bit) at rd_addr.
  - Adds input inj_parity_err (1 bit): when 1 during a write, the stored parity bits of the written lanes are inverted. This exists for test only.
- Not defined: no parity storage, and neither extra port exists.

Decomposition:
- Shared package cache_pkg:
  - constants CACHE_INDEX_W=5, CACHE_WORD_W=32, CACHE_BYTE_NUM=4, CACHE_WORDS_PER_LINE=4;
  - typedefs cache_index_t, cache_word_t, cache_byte_en_t.
- Natural sub-module cache_bank_byte_lane: one 8-bit (plus optional parity) x depth array with its own enable and async clear. Generate BYTE_NUM instances.

Test Plan:
- Reset: assert rst mid-run after writing 0xDEADBEEF to addr 3 -> rd_data=0 immediately at addr 3; after release, reads 0 at all 32 addresses.
- Full write and read-back: write 0xDEADBEEF with wr_byte_en=4'hF to addr 5 -> rd_data=0xDEADBEEF at rd_addr=5 right after the edge; addr 4 and 6 still read 0.
- Byte merge:
  - addr 5 holds 0xDEADBEEF; write 0x11223344 with wr_byte_en=4'b0101 -> rd_data=0xDE22BE44.
  - Then write 0x55667788 with wr_byte_en=4'b0000 -> still 0xDE22BE44.
- Write gating and boundaries:
  - wr_en=0 with byte_en=4'hF and data 0xFFFFFFFF at addr 0 -> still 0.
  - Write 0xA5A5A5A5 to addr 31 and 0x5A5A5A5A to addr 0 -> both read back correctly and independently.
- Read-during-write: rd_addr=wr_addr=9, old 0x00000001, write 0xCAFEF00D full -> rd_data=0x00000001 before the edge, 0xCAFEF00D after.
- Parity (with CACHE_BANK_RAM_PARITY_EN):
  - Write 0x01020304 clean -> rd_parity_err=0.
  - Rewrite with inj_parity_err=1, wr_byte_en=4'b0001 -> rd_parity_err=1.
  - Rewrite clean -> 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache constants and types used by the data-bank RAM and its way controller.
package cache_pkg;

  localparam int CACHE_INDEX_W        = 5;
  localparam int CACHE_WORD_W         = 32;
  localparam int CACHE_BYTE_NUM       = 4;
  localparam int CACHE_WORDS_PER_LINE = 4;

  typedef logic [CACHE_INDEX_W-1:0]  cache_index_t;
  typedef logic [CACHE_WORD_W-1:0]   cache_word_t;
  typedef logic [CACHE_BYTE_NUM-1:0] cache_byte_en_t;

endpackage

// File: rtl/cache_bank_byte_lane.sv
// One byte lane of a cache data bank: depth x 8-bit array with write enable,
// asynchronous clear and combinational read.
// Optional feature macro: CACHE_BANK_RAM_PARITY_EN adds a stored even-parity
// bit per entry, a test-only parity inversion input and a parity-error output.
module cache_bank_byte_lane #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_byte,
`ifdef CACHE_BANK_RAM_PARITY_EN
  input  logic                  inj_parity_err,
  output logic                  rd_parity_err,
`endif
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_byte
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem_q [DEPTH];

  // Byte storage: cleared as soon as reset rises, written on the clock edge otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_byte;
    end
  end

  assign rd_byte = mem_q[rd_addr];

`ifdef CACHE_BANK_RAM_PARITY_EN
  logic par_q [DEPTH];
  logic par_d;

  // Even parity of the incoming byte, optionally inverted to plant an error.
  always_comb begin
    par_d = (^wr_byte) ^ inj_parity_err;
  end

  // Parity storage follows the byte storage exactly; zero is consistent with a zero byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      par_q[wr_addr] <= par_d;
    end
  end

  assign rd_parity_err = (^mem_q[rd_addr]) ^ par_q[rd_addr];
`endif

endmodule

// File: rtl/cache_bank_ram.sv
// One data bank of a cache way: 2^ADDR_WIDTH words, byte-granular writes,
// zero-latency combinational read with no bypass (read-during-write returns
// the old word until the edge). Built from BYTE_NUM independent byte lanes.
// Optional feature macro: CACHE_BANK_RAM_PARITY_EN adds per-byte even parity,
// the rd_parity_err output and the test-only inj_parity_err input.
module cache_bank_ram
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_INDEX_W,
  parameter int DATA_WIDTH = CACHE_WORD_W,
  parameter int BYTE_NUM   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BYTE_NUM-1:0]   wr_byte_en,
`ifdef CACHE_BANK_RAM_PARITY_EN
  input  logic                  inj_parity_err,
  output logic                  rd_parity_err,
`endif
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

`ifdef CACHE_BANK_RAM_PARITY_EN
  logic [BYTE_NUM-1:0] lane_err;
`endif

  for (genvar k = 0; k < BYTE_NUM; k++) begin : g_lane
    logic lane_wr_en;

    // A lane writes only when the bank strobe and its own byte enable are both set.
    always_comb begin
      lane_wr_en = wr_en & wr_byte_en[k];
    end

    cache_bank_byte_lane #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (lane_wr_en),
      .wr_addr       (wr_addr),
      .wr_byte       (wr_data[8*k +: 8]),
`ifdef CACHE_BANK_RAM_PARITY_EN
      .inj_parity_err(inj_parity_err),
      .rd_parity_err (lane_err[k]),
`endif
      .rd_addr       (rd_addr),
      .rd_byte       (rd_data[8*k +: 8])
    );
  end

`ifdef CACHE_BANK_RAM_PARITY_EN
  assign rd_parity_err = |lane_err;
`endif

endmodule

// File: tb/tb_cache_bank_ram.sv
// Directed bench for cache_bank_ram: reset, full/partial writes, gating,
// address boundaries, read-during-write and (when enabled) parity.
module tb_cache_bank_ram;
  import cache_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           wr_en      = 1'b0;
  cache_index_t   wr_addr    = '0;
  cache_word_t    wr_data    = '0;
  cache_byte_en_t wr_byte_en = '0;
  cache_index_t   rd_addr    = '0;
  cache_word_t    rd_data;
`ifdef CACHE_BANK_RAM_PARITY_EN
  logic inj_parity_err = 1'b0;
  logic rd_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  cache_bank_ram dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_byte_en    (wr_byte_en),
`ifdef CACHE_BANK_RAM_PARITY_EN
    .inj_parity_err(inj_parity_err),
    .rd_parity_err (rd_parity_err),
`endif
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one write cycle, inputs changed at the falling edge
  task automatic do_write(input cache_index_t a, input cache_word_t d,
                          input cache_byte_en_t be, input logic en);
    @(negedge clk);
    wr_addr    = a;
    wr_data    = d;
    wr_byte_en = be;
    wr_en      = en;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Driver + check: read an address away from the clock edge
  task automatic check_rd(input string tag, input cache_index_t a, input cache_word_t exp);
    @(negedge clk);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    // Reset state
    rd_addr = 5'd0;
    #2;
    check("rst_addr0", rd_data, 32'h0);
    rd_addr = 5'd31;
    #1;
    check("rst_addr31", rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-run reset clears immediately; a write during reset is lost
    do_write(5'd3, 32'hDEADBEEF, 4'hF, 1'b1);
    check_rd("pre_rst_addr3", 5'd3, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    check("rst_immediate_addr3", rd_data, 32'h0);
    do_write(5'd7, 32'hFFFFFFFF, 4'hF, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check_rd($sformatf("post_rst_addr%0d", i), cache_index_t'(i), 32'h0);
    end

    // Full write and neighbours
    do_write(5'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    rd_addr = 5'd5;
    #1;
    check("full_wr_addr5", rd_data, 32'hDEADBEEF);
    check_rd("full_wr_addr4", 5'd4, 32'h0);
    check_rd("full_wr_addr6", 5'd6, 32'h0);

    // Byte merge and zero byte enable
    do_write(5'd5, 32'h11223344, 4'b0101, 1'b1);
    check_rd("merge_0101", 5'd5, 32'hDE22BE44);
    do_write(5'd5, 32'h55667788, 4'b0000, 1'b1);
    check_rd("merge_be0", 5'd5, 32'hDE22BE44);
    do_write(5'd5, 32'hAABBCCDD, 4'b1000, 1'b1);
    check_rd("merge_1000", 5'd5, 32'hAA22BE44);

    // Write gating and address boundaries
    do_write(5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
    check_rd("gated_addr0", 5'd0, 32'h0);
    do_write(5'd31, 32'hA5A5A5A5, 4'hF, 1'b1);
    do_write(5'd0, 32'h5A5A5A5A, 4'hF, 1'b1);
    check_rd("bound_addr31", 5'd31, 32'hA5A5A5A5);
    check_rd("bound_addr0", 5'd0, 32'h5A5A5A5A);
    check_rd("bound_addr30", 5'd30, 32'h0);
    check_rd("bound_addr1", 5'd1, 32'h0);

    // Read-during-write on the same address: old word before the edge, new after
    do_write(5'd9, 32'h00000001, 4'hF, 1'b1);
    @(negedge clk);
    rd_addr    = 5'd9;
    wr_addr    = 5'd9;
    wr_data    = 32'hCAFEF00D;
    wr_byte_en = 4'hF;
    wr_en      = 1'b1;
    #1;
    check("rdw_before", rd_data, 32'h00000001);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("rdw_after", rd_data, 32'hCAFEF00D);
    check_rd("rdw_addr5_untouched", 5'd5, 32'hAA22BE44);

`ifdef CACHE_BANK_RAM_PARITY_EN
    // Parity: clean write, injected error on lane 0, clean rewrite
    do_write(5'd12, 32'h01020304, 4'hF, 1'b1);
    check_rd("par_clean_data", 5'd12, 32'h01020304);
    check("par_clean_err", {31'b0, rd_parity_err}, 32'h0);
    inj_parity_err = 1'b1;
    do_write(5'd12, 32'h01020304, 4'b0001, 1'b1);
    inj_parity_err = 1'b0;
    check_rd("par_inj_data", 5'd12, 32'h01020304);
    check("par_inj_err", {31'b0, rd_parity_err}, 32'h1);
    check_rd("par_other_addr", 5'd5, 32'hAA22BE44);
    check("par_other_err", {31'b0, rd_parity_err}, 32'h0);
    do_write(5'd12, 32'h01020304, 4'hF, 1'b1);
    check_rd("par_rewrite_data", 5'd12, 32'h01020304);
    check("par_rewrite_err", {31'b0, rd_parity_err}, 32'h0);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
